// File: rtl/mem_dcache_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_dcache_stage
// Purpose  : MEM stage of the 16-bit 5-stage pipeline. Passes ALU results
//            through to WB and serves LOADs from a direct-mapped, one-word-
//            per-line, write-through, no-write-allocate data cache. Misses and
//            all STOREs go to main memory over a req/ack handshake.
// Ports    : clock, reset (async, active-high)
//            state          1 = CPU executing, 0 = idle
//            mem_ir/reg_C/smdr1/dw   instruction, address/result, store data
//                                    and store strobe from EX
//            wb_ir/reg_C1   instruction and result towards WB
//            stall          combinational hold request to upstream stages
//            mm_req/mm_we/mm_addr/mm_wdata/mm_rdata/mm_ack  main memory
//            hit_cnt/miss_cnt  LOAD hit/miss counters (only with
//                              DCACHE_STATS_EN defined)
// Options  : `define DCACHE_STATS_EN to add the saturating statistics counters.
// Revision : 1.0 - initial release
//==============================================================================
module mem_dcache_stage #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 16 - INDEX_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic [15:0] smdr1,
    input  logic        dw,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        stall,
    output logic        mm_req,
    output logic        mm_we,
    output logic [15:0] mm_addr,
    output logic [15:0] mm_wdata,
    input  logic [15:0] mm_rdata,
    input  logic        mm_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int         c_LINES    = 1 << INDEX_W;
    localparam logic [4:0] c_OP_LOAD  = 5'b00010;
    localparam logic [4:0] c_OP_STORE = 5'b00011;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0]         r_state;
    logic [c_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_LINES];
    logic [15:0]        r_data [c_LINES];
    logic [15:0]        r_ir;

    logic               w_is_load;
    logic               w_is_store;
    logic [INDEX_W-1:0] w_idx;
    logic               w_hit;
    logic [INDEX_W-1:0] w_l_idx;
    logic               w_l_hit;
    logic               w_active;
    logic               w_load_hit;
    logic               w_start_fill;
    logic               w_start_write;
    logic               w_fill_done;
    logic               w_write_done;

    // Lookup on the address presented by EX.
    assign w_is_load  = (mem_ir[15:11] == c_OP_LOAD);
    assign w_is_store = (mem_ir[15:11] == c_OP_STORE) && dw;
    assign w_idx      = reg_C[INDEX_W-1:0];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == reg_C[15:INDEX_W]);

    // Lookup on the latched transaction address; mm_addr doubles as the latch.
    assign w_l_idx    = mm_addr[INDEX_W-1:0];
    assign w_l_hit    = r_valid[w_l_idx] && (r_tag[w_l_idx] == mm_addr[15:INDEX_W]);

    assign w_active      = (r_state == c_IDLE) && state;
    assign w_load_hit    = w_active && w_is_load && w_hit;
    assign w_start_fill  = w_active && w_is_load && !w_hit;
    assign w_start_write = w_active && w_is_store;
    assign w_fill_done   = (r_state == c_FILL) && mm_ack;
    assign w_write_done  = (r_state == c_WRITE) && mm_ack;

    // Hold upstream from the very cycle a miss/store is seen until the ack
    // cycle; the ack cycle itself releases so EX can advance in step.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            c_FILL, c_WRITE: stall = ~mm_ack;
            default:         stall = w_start_fill | w_start_write;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_ir     <= 16'h0000;
            wb_ir    <= 16'h0000;
            reg_C1   <= 16'h0000;
            mm_req   <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= 16'h0000;
            mm_wdata <= 16'h0000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start_fill) begin
                        r_ir    <= mem_ir;
                        mm_addr <= reg_C;
                        mm_req  <= 1'b1;
                        mm_we   <= 1'b0;
                        wb_ir   <= 16'h0000;
                        r_state <= c_FILL;
                    end else if (w_start_write) begin
                        r_ir     <= mem_ir;
                        mm_addr  <= reg_C;
                        mm_wdata <= smdr1;
                        mm_req   <= 1'b1;
                        mm_we    <= 1'b1;
                        wb_ir    <= 16'h0000;
                        r_state  <= c_WRITE;
                    end else if (state) begin
                        wb_ir  <= mem_ir;
                        reg_C1 <= w_load_hit ? r_data[w_idx] : reg_C;
                    end
                end
                c_FILL, c_WRITE: begin
                    if (mm_ack) begin
                        mm_req  <= 1'b0;
                        mm_we   <= 1'b0;
                        wb_ir   <= r_ir;
                        reg_C1  <= (r_state == c_FILL) ? mm_rdata : mm_addr;
                        r_state <= c_IDLE;
                    end else begin
                        wb_ir <= 16'h0000;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_fill_done) begin
            r_valid[w_l_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only ever read behind its valid bit.
    // Write-through stores only refresh a line that already holds the address.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_fill_done) begin
                r_tag[w_l_idx]  <= mm_addr[15:INDEX_W];
                r_data[w_l_idx] <= mm_rdata;
            end else if (w_write_done && w_l_hit) begin
                r_data[w_l_idx] <= mm_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (w_load_hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (w_start_fill && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_dcache_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_dcache_stage
// Purpose  : Self-checking bench for mem_dcache_stage. The bench plays main
//            memory and keeps an address-level model of cache contents and
//            of the outputs expected each cycle; one negedge process compares.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_dcache_stage;

    localparam int IW    = 3;
    localparam int LINES = 1 << IW;

    localparam logic [15:0] LD  = 16'h10A5;   // opcode 00010
    localparam logic [15:0] ST  = 16'h18C3;   // opcode 00011
    localparam logic [15:0] ADD = 16'h0841;   // opcode 00001

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] mem_ir, reg_C, smdr1;
    logic        dw;
    logic [15:0] wb_ir, reg_C1;
    logic        stall, mm_req, mm_we;
    logic [15:0] mm_addr, mm_wdata, mm_rdata;
    logic        mm_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    mem_dcache_stage #(.INDEX_W(IW)) dut (
        .clock(clock), .reset(reset), .state(state),
        .mem_ir(mem_ir), .reg_C(reg_C), .smdr1(smdr1), .dw(dw),
        .wb_ir(wb_ir), .reg_C1(reg_C1), .stall(stall),
        .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_ack(mm_ack)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Model: which word address each cache index holds, and backing memory.
    logic        m_valid [LINES];
    logic [15:0] m_addr  [LINES];
    logic [15:0] m_data  [LINES];
    logic [15:0] m_mem   [int];
    int          m_hits, m_miss;

    // Expected outputs for the current cycle.
    logic [15:0] e_wb, e_c1, e_addr, e_wdata;
    logic        e_stall, e_req, e_we;
    logic        chk_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_stall = 0;
    int s0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        e_wb = 16'h0; e_c1 = 16'h0; e_addr = 16'h0; e_wdata = 16'h0;
        e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
        m_hits = 0; m_miss = 0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            if (stall) n_stall++;
            cmp("wb_ir", wb_ir, e_wb);
            cmp("reg_C1", reg_C1, e_c1);
            cmp("stall", {15'b0, stall}, {15'b0, e_stall});
            cmp("mm_req", {15'b0, mm_req}, {15'b0, e_req});
            if (e_req) begin
                cmp("mm_we", {15'b0, mm_we}, {15'b0, e_we});
                cmp("mm_addr", mm_addr, e_addr);
                if (e_we) cmp("mm_wdata", mm_wdata, e_wdata);
            end
`ifdef DCACHE_STATS_EN
            cmp("hit_cnt", hit_cnt, 16'(m_hits));
            cmp("miss_cnt", miss_cnt, 16'(m_miss));
`endif
        end
    end

    // One instruction through MEM. nack = waiting cycles before the ack.
    task automatic op(input logic [15:0] ir, input logic [15:0] a,
                      input logic [15:0] d, input logic s, input int nack);
        logic is_ld, is_st, hit;
        int   idx;
        is_ld = (ir[15:11] == 5'b00010);
        is_st = (ir[15:11] == 5'b00011) && s;
        idx   = int'(a[IW-1:0]);
        hit   = m_valid[idx] && (m_addr[idx] == a);
        state = 1'b1; mem_ir = ir; reg_C = a; smdr1 = d; dw = s; mm_ack = 1'b0;
        if (!is_st && !(is_ld && !hit)) begin
            e_stall = 1'b0;
            step();
            e_wb = ir;
            e_c1 = is_ld ? m_data[idx] : a;
            if (is_ld) m_hits++;
        end else begin
            e_stall = 1'b1;
            step();
            e_wb = 16'h0; e_req = 1'b1; e_we = is_st; e_addr = a;
            if (is_st) e_wdata = d;
            if (is_ld) m_miss++;
            // Inputs need not hold during the transaction; scramble them.
            state = 1'b0; mem_ir = ~ir; reg_C = ~a; smdr1 = ~d; dw = ~s;
            for (int k = 0; k < nack; k++) begin
                e_stall = 1'b1;
                step();
                e_wb = 16'h0;
            end
            mm_ack = 1'b1;
            mm_rdata = is_ld ? mem_rd(a) : 16'hDEAD;
            e_stall = 1'b0;
            step();
            mm_ack = 1'b0; mm_rdata = 16'h0;
            e_req = 1'b0; e_we = 1'b0; e_wb = ir;
            if (is_ld) begin
                e_c1 = mem_rd(a);
                m_valid[idx] = 1'b1; m_addr[idx] = a; m_data[idx] = e_c1;
            end else begin
                e_c1 = a;
                m_mem[int'(a)] = d;
                if (hit) m_data[idx] = d;
            end
        end
    endtask

    // CPU idle: memory-looking inputs must be ignored, optionally with a stray ack.
    task automatic idle(input int n, input logic stray_ack);
        state = 1'b0; mem_ir = LD; reg_C = 16'h0077; dw = 1'b0;
        mm_ack = stray_ack; mm_rdata = 16'hFACE;
        e_stall = 1'b0;
        for (int k = 0; k < n; k++) step();
        mm_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; state = 1'b0; mem_ir = 16'h0; reg_C = 16'h0; smdr1 = 16'h0;
        dw = 1'b0; mm_rdata = 16'h0; mm_ack = 1'b0;
        model_reset();
        m_mem[16'h0012] = 16'hBEEF;
        m_mem[16'h001A] = 16'h5555;
        m_mem[16'h0033] = 16'h3333;
        m_mem[16'h0040] = 16'h7777;
        step(); step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Reset asserted while a FILL is outstanding.
        state = 1'b1; mem_ir = LD; reg_C = 16'h0033; dw = 1'b0;
        e_stall = 1'b1;
        step();
        e_wb = 16'h0; e_req = 1'b1; e_we = 1'b0; e_addr = 16'h0033; m_miss++;
        state = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        cmp("rst_fill_req_async", {15'b0, mm_req}, 16'h0000);
        cmp("rst_fill_stall", {15'b0, stall}, 16'h0000);
        step();
        reset = 1'b0;
        step();
`ifdef DCACHE_STATS_EN
        cmp("lit_hit_cnt0", hit_cnt, 16'h0000);
        cmp("lit_miss_cnt0", miss_cnt, 16'h0000);
`endif

        // Cold load then hit.
        s0 = n_stall;
        op(LD, 16'h0012, 16'h0, 1'b0, 2);
        cmp("lit_cold_stall_cycles", 16'(n_stall - s0), 16'd3);
        cmp("lit_cold_c1", reg_C1, 16'hBEEF);
        cmp("lit_cold_wb", wb_ir, LD);
        s0 = n_stall;
        op(LD, 16'h0012, 16'h0, 1'b0, 0);
        cmp("lit_hit_stall_cycles", 16'(n_stall - s0), 16'd0);
        cmp("lit_hit_c1", reg_C1, 16'hBEEF);
`ifdef DCACHE_STATS_EN
        cmp("lit_hit_cnt1", hit_cnt, 16'h0001);
        cmp("lit_miss_cnt1", miss_cnt, 16'h0001);
`endif

        // Conflict on index 2 evicts 0x0012.
        op(LD, 16'h001A, 16'h0, 1'b0, 1);
        cmp("lit_evict_c1", reg_C1, 16'h5555);
        s0 = n_stall;
        op(LD, 16'h0012, 16'h0, 1'b0, 1);
        cmp("lit_remiss_stall_cycles", 16'(n_stall - s0), 16'd2);

        // Store to a cached line updates it.
        op(ST, 16'h0012, 16'h1234, 1'b1, 1);
        cmp("lit_store_c1", reg_C1, 16'h0012);
        s0 = n_stall;
        op(LD, 16'h0012, 16'h0, 1'b0, 0);
        cmp("lit_store_hit_stall", 16'(n_stall - s0), 16'd0);
        cmp("lit_store_hit_c1", reg_C1, 16'h1234);

        // Store to an uncached line does not allocate.
        op(ST, 16'h0040, 16'hABCD, 1'b1, 0);
        s0 = n_stall;
        op(LD, 16'h0040, 16'h0, 1'b0, 1);
        cmp("lit_noalloc_stall", 16'(n_stall - s0), 16'd2);
        cmp("lit_noalloc_c1", reg_C1, 16'hABCD);

        // ALU passthrough, then idle CPU with a stray ack.
        op(ADD, 16'h0005, 16'h0, 1'b0, 0);
        cmp("lit_add_c1", reg_C1, 16'h0005);
        cmp("lit_add_wb", wb_ir, ADD);
        idle(3, 1'b1);
        cmp("lit_idle_c1", reg_C1, 16'h0005);

        // STORE opcode without dw behaves as a passthrough.
        op(ST, 16'h0012, 16'h9999, 1'b0, 0);
        op(LD, 16'h0012, 16'h0, 1'b0, 0);
        cmp("lit_nodw_c1", reg_C1, 16'h1234);

        // Mid-run reset invalidates everything.
        state = 1'b0; reset = 1'b1;
        model_reset();
        step(); step();
        reset = 1'b0;
        cmp("lit_rst_wb", wb_ir, 16'h0000);
        cmp("lit_rst_c1", reg_C1, 16'h0000);
        s0 = n_stall;
        op(LD, 16'h001A, 16'h0, 1'b0, 1);
        cmp("lit_rst_miss_stall", 16'(n_stall - s0), 16'd2);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
